// File: rtl/grf_writeback_pkg.sv
`default_nettype none
// ============================================================================
// Module      : grf_writeback_pkg
// Description : Shared pipeline definitions: default widths, the zero-register
//               index and the commit trace record used by stage trace ports.
// Revision    : 1.0 - initial release
// ============================================================================
package grf_writeback_pkg;

    localparam int unsigned GRF_DATA_W = 32;
    localparam int unsigned GRF_ADDR_W = 5;
    localparam int unsigned REG_ZERO   = 0;
    localparam int unsigned PC_W       = 32;

    typedef struct packed {
        logic                  valid;
        logic [PC_W-1:0]       pc;
        logic [GRF_ADDR_W-1:0] rd_idx;
        logic [GRF_DATA_W-1:0] data;
    } commit_trace_t;

    // The W stage carries PC+4; traces report the instruction's own PC.
    function automatic logic [PC_W-1:0] pc_of_pc4(input logic [PC_W-1:0] pc4);
        return pc4 - PC_W'(4);
    endfunction

endpackage : grf_writeback_pkg
`default_nettype wire

// File: rtl/grf_read_port.sv
`default_nettype none
// ============================================================================
// Module      : grf_read_port
// Description : One register-file read port with same-cycle W-stage bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module grf_read_port
    import grf_writeback_pkg::*;
#(
    parameter int unsigned DATA_W = GRF_DATA_W,
    parameter int unsigned ADDR_W = GRF_ADDR_W
) (
    input  logic [ADDR_W-1:0]                i_ra,
    input  logic [(2**ADDR_W)*DATA_W-1:0]    i_regs_flat,
    input  logic                             i_commit,
    input  logic [ADDR_W-1:0]                i_a3,
    input  logic [DATA_W-1:0]                i_wd,
    output logic [DATA_W-1:0]                o_rd
);

    logic [DATA_W-1:0] w_array_data;
    logic              w_is_zero;
    logic              w_bypass;

    assign w_array_data = i_regs_flat[i_ra*DATA_W +: DATA_W];
    assign w_is_zero    = (i_ra == ADDR_W'(REG_ZERO));
    assign w_bypass     = i_commit && (i_a3 == i_ra);

    // Register 0 wins over the bypass so a no-op write never leaks through.
    always_comb begin
        o_rd = w_array_data;
        if (w_is_zero) begin
            o_rd = '0;
        end else if (w_bypass) begin
            o_rd = i_wd;
        end
    end

endmodule : grf_read_port
`default_nettype wire

// File: rtl/grf_writeback.sv
`default_nettype none
// ============================================================================
// Module      : grf_writeback
// Description : 32x32 general register file fed by the W stage, with two
//               bypassed D-stage read ports, commit trace and commit counter.
// Revision    : 1.0 - initial release
// ============================================================================
module grf_writeback
    import grf_writeback_pkg::*;
#(
    parameter int unsigned DATA_W = GRF_DATA_W,
    parameter int unsigned ADDR_W = GRF_ADDR_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                we,
    input  logic [ADDR_W-1:0]   a3,
    input  logic [DATA_W-1:0]   wd,
    input  logic [31:0]         pc4_w,
    input  logic [ADDR_W-1:0]   ra1,
    input  logic [ADDR_W-1:0]   ra2,
    output logic [DATA_W-1:0]   rd1,
    output logic [DATA_W-1:0]   rd2,
    output logic                trace_valid,
    output logic [31:0]         trace_pc,
    output logic [ADDR_W-1:0]   trace_reg,
    output logic [DATA_W-1:0]   trace_data,
    output logic [31:0]         commit_count
);

    localparam int unsigned C_NREGS = 2**ADDR_W;

    logic [DATA_W-1:0]          r_regs [C_NREGS];
    logic [C_NREGS*DATA_W-1:0]  w_regs_flat;
    logic                       w_commit;

    logic                       r_trace_valid;
    logic [31:0]                r_trace_pc;
    logic [ADDR_W-1:0]          r_trace_reg;
    logic [DATA_W-1:0]          r_trace_data;
    logic [31:0]                r_commit_count;

    assign w_commit = we && (a3 != ADDR_W'(REG_ZERO));

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < C_NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_commit) begin
            r_regs[a3] <= wd;
        end
    end

    generate
        for (genvar g = 0; g < C_NREGS; g++) begin : g_flat
            assign w_regs_flat[g*DATA_W +: DATA_W] = r_regs[g];
        end
    endgenerate

    grf_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_read_port1 (
        .i_ra        (ra1),
        .i_regs_flat (w_regs_flat),
        .i_commit    (w_commit),
        .i_a3        (a3),
        .i_wd        (wd),
        .o_rd        (rd1)
    );

    grf_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_read_port2 (
        .i_ra        (ra2),
        .i_regs_flat (w_regs_flat),
        .i_commit    (w_commit),
        .i_a3        (a3),
        .i_wd        (wd),
        .o_rd        (rd2)
    );

    // trace_pc follows every cycle; reg/data keep the last real commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_trace_valid  <= 1'b0;
            r_trace_pc     <= '0;
            r_trace_reg    <= '0;
            r_trace_data   <= '0;
            r_commit_count <= '0;
        end else begin
            r_trace_valid <= w_commit;
            r_trace_pc    <= pc_of_pc4(pc4_w);
            if (w_commit) begin
                r_trace_reg  <= a3;
                r_trace_data <= wd;
                if (r_commit_count != 32'hFFFF_FFFF) begin
                    r_commit_count <= r_commit_count + 32'd1;
                end
            end
        end
    end

    assign trace_valid  = r_trace_valid;
    assign trace_pc     = r_trace_pc;
    assign trace_reg    = r_trace_reg;
    assign trace_data   = r_trace_data;
    assign commit_count = r_commit_count;

endmodule : grf_writeback
`default_nettype wire

// File: tb/tb_grf_writeback.sv
`default_nettype none
// ============================================================================
// Module      : tb_grf_writeback
// Description : Scoreboard bench for grf_writeback: directed plan plus random
//               traffic against an array-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_grf_writeback;

    logic        clk;
    logic        reset;
    logic        we;
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] pc4_w;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        trace_valid;
    logic [31:0] trace_pc;
    logic [4:0]  trace_reg;
    logic [31:0] trace_data;
    logic [31:0] commit_count;

    int checks = 0;
    int errors = 0;

    grf_writeback dut (
        .clk          (clk),
        .reset        (reset),
        .we           (we),
        .a3           (a3),
        .wd           (wd),
        .pc4_w        (pc4_w),
        .ra1          (ra1),
        .ra2          (ra2),
        .rd1          (rd1),
        .rd2          (rd2),
        .trace_valid  (trace_valid),
        .trace_pc     (trace_pc),
        .trace_reg    (trace_reg),
        .trace_data   (trace_data),
        .commit_count (commit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        chk;
        logic [31:0] e1;
        logic [31:0] e2;
    } rd_exp_t;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic [4:0]  r;
        logic [31:0] d;
        logic [31:0] cnt;
    } tr_exp_t;

    rd_exp_t rdq[$];
    tr_exp_t trq[$];

    // Reference model state
    logic [31:0] mem [32];
    tr_exp_t     m_tr;
    logic        known = 1'b0;

    function automatic logic [31:0] model_read(input logic [4:0] r, input logic cm,
                                               input logic [4:0] wa, input logic [31:0] wv);
        if (r == 5'd0) return 32'd0;
        if (cm && wa == r) return wv;
        return mem[r];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus; expectations go to the scoreboard queues.
    task automatic cycle(input logic rs, input logic w, input logic [4:0] wa,
                         input logic [31:0] wv, input logic [31:0] pc4,
                         input logic [4:0] r1, input logic [4:0] r2);
        logic    cm;
        rd_exp_t re;
        reset = rs; we = w; a3 = wa; wd = wv; pc4_w = pc4; ra1 = r1; ra2 = r2;
        cm = w && (wa != 5'd0);
        re.chk = known;
        re.e1  = model_read(r1, cm, wa, wv);
        re.e2  = model_read(r2, cm, wa, wv);
        rdq.push_back(re);
        if (rs) begin
            for (int i = 0; i < 32; i++) mem[i] = 32'd0;
            m_tr = '{v: 1'b0, pc: 32'd0, r: 5'd0, d: 32'd0, cnt: 32'd0};
            known = 1'b1;
        end else begin
            m_tr.v  = cm;
            m_tr.pc = pc4 - 32'd4;
            if (cm) begin
                mem[wa] = wv;
                m_tr.r  = wa;
                m_tr.d  = wv;
                if (m_tr.cnt != 32'hFFFF_FFFF) m_tr.cnt = m_tr.cnt + 32'd1;
            end
        end
        @(posedge clk);
        #1;
        if (known) trq.push_back(m_tr);
    endtask

    task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 32'h0000_1004, r1, r2);
    endtask

    // Monitor: compares whatever the DUT presents mid-cycle.
    always @(negedge clk) begin
        rd_exp_t re;
        tr_exp_t te;
        if (rdq.size() > 0) begin
            re = rdq.pop_front();
            if (re.chk) begin
                check("rd1", rd1, re.e1);
                check("rd2", rd2, re.e2);
            end
        end
        if (trq.size() > 0) begin
            te = trq.pop_front();
            check("trace_valid", {31'd0, trace_valid}, {31'd0, te.v});
            check("trace_pc", trace_pc, te.pc);
            check("trace_reg", {27'd0, trace_reg}, {27'd0, te.r});
            check("trace_data", trace_data, te.d);
            check("commit_count", commit_count, te.cnt);
        end
    end

    initial begin
        logic [4:0]  wa;
        logic [31:0] pc;
        reset = 1'b1; we = 1'b0; a3 = '0; wd = '0; pc4_w = '0; ra1 = '0; ra2 = '0;
        @(posedge clk);
        #1;
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        for (int i = 0; i < 32; i++) idle(5'(i), 5'(31 - i));

        // Single commit, then read back from the array
        cycle(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 32'h0000_3004, 5'd5, 5'd0);
        idle(5'd5, 5'd5);

        // Write to register 0 is a no-op
        cycle(1'b0, 1'b1, 5'd0, 32'h1234_5678, 32'h0000_3008, 5'd0, 5'd0);
        idle(5'd0, 5'd5);

        // Back-to-back commits
        cycle(1'b0, 1'b1, 5'd1, 32'd1, 32'h0000_3010, 5'd1, 5'd0);
        cycle(1'b0, 1'b1, 5'd2, 32'd2, 32'h0000_3014, 5'd1, 5'd2);
        cycle(1'b0, 1'b1, 5'd3, 32'd3, 32'h0000_3018, 5'd2, 5'd3);
        idle(5'd2, 5'd3);

        // Reset beats a simultaneous commit
        cycle(1'b0, 1'b1, 5'd7, 32'hAAAA_AAAA, 32'h0000_3020, 5'd7, 5'd1);
        cycle(1'b1, 1'b1, 5'd7, 32'h5555_5555, 32'h0000_3024, 5'd7, 5'd7);
        idle(5'd7, 5'd3);

        // Dual bypass of the same register, then no false bypass
        cycle(1'b0, 1'b1, 5'd9, 32'hCAFE_0009, 32'h0000_3030, 5'd9, 5'd9);
        cycle(1'b0, 1'b1, 5'd10, 32'h0000_000A, 32'h0000_3034, 5'd9, 5'd10);
        idle(5'd9, 5'd10);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            wa = 5'($urandom_range(0, 31));
            pc = $urandom;
            cycle(($urandom_range(0, 59) == 0),
                  ($urandom_range(0, 3) != 0),
                  wa, $urandom, pc,
                  ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31)));
        end
        idle(5'd0, 5'd0);

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_grf_writeback
`default_nettype wire

// File: doc/grf_writeback.md
# grf_writeback

Register file and writeback sink for the five-stage MIPS pipeline. It consumes the W-stage outputs (destination register, write data, PC+4) and commits them to the 32×32 general register file. It serves the D-stage's two read ports with same-cycle write-through bypass. It also emits a registered one-line commit trace for the bench's golden-model comparison.

## Interface
- DATA_W, 32: register and data width.
- ADDR_W, 5: register index width (2^ADDR_W registers).
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- we  in  1  W-stage write request (from W-stage control decode).
- a3  in  ADDR_W  W-stage destination register index.
- wd  in  DATA_W  W-stage write data.
- pc4_w  in  32  W-stage PC+4 of the committing instruction.
- ra1, ra2  in  ADDR_W  D-stage read indices.
- rd1, rd2  out  DATA_W  D-stage read data (combinational, bypassed).
- trace_valid  out  1  a commit occurred in the previous cycle.
- trace_pc  out  32  PC of that commit (pc4_w − 4).
- trace_reg  out  ADDR_W  destination index of that commit.
- trace_data  out  DATA_W  value written.
- commit_count  out  32  number of commits since reset, saturating.

## Operation
- Effective write: commit = we && (a3 != 0). Register 0 is never written and always reads 0.
- On posedge clk with commit, regs[a3] ← wd. Without commit, the array holds.
- Read: rdN = 0 if raN == 0. Otherwise rdN = wd if commit && (a3 == raN). Otherwise rdN = regs[raN]. The D stage therefore sees the W-stage value in the same cycle, with no extra forwarding mux needed for the W→D distance.
- Trace: on each clock, trace_valid ← commit, and trace_pc ← pc4_w − 32'd4 (modulo 2^32). trace_reg ← a3 and trace_data ← wd are loaded only when commit; otherwise they hold their previous value.
- commit_count increments by 1 per commit and holds at 32'hFFFF_FFFF.
- A write with we=1 and a3=0 is a legal no-op: no array change, trace_valid=0, and the count is unchanged.

## Timing
- Reset, synchronous: all 32 registers ← 0, trace_valid ← 0, trace_pc ← 0, trace_reg ← 0, trace_data ← 0, commit_count ← 0.
- Reset takes priority over a simultaneous commit; that write is lost.
- Reset asserted mid-run clears the array on that edge. Reads in the following cycle return 0 for every index.
- Write latency: one edge. Bypass makes the new value visible on rd1/rd2 in the commit cycle itself.
- Trace latency: exactly one cycle after the commit edge. trace_valid is a one-cycle pulse per commit, so back-to-back commits give consecutive pulses.
- Simultaneous ra1 == ra2 == a3: both ports bypass the same wd.
- rd1/rd2 have no registered output. The read path is a mux on the array plus the bypass compare and must meet single-cycle D-stage timing.

## Structure
- Shared pipeline package: DATA_W/ADDR_W defaults, the constant REG_ZERO = 0, and the commit trace record (valid, pc, reg, data) as a packed typedef, reused by the other stage modules' trace ports.
- One natural sub-module, grf_read_port (one read index in, one bypassed data out), instantiated twice. The array, write logic, trace and counter live in grf_writeback.

## Test plan
- Reset then read all 32 indices on both ports -> every rd = 0, trace_valid = 0, commit_count = 0.
- we=1, a3=5, wd=32'hDEAD_BEEF, pc4_w=32'h0000_3004, ra1=5 -> rd1=32'hDEAD_BEEF in the same cycle. Next cycle: trace_valid=1, trace_pc=32'h0000_3000, trace_reg=5, commit_count=1, and rd1 still reads 32'hDEAD_BEEF from the array with we=0.
- we=1, a3=0, wd=32'h1234_5678, ra1=0 -> rd1=0 in that cycle. Next cycle: trace_valid=0, commit_count unchanged.
- Commits to regs 1, 2, 3 on consecutive cycles with values 1, 2, 3 -> trace_valid high three consecutive cycles with trace_reg 1, 2, 3. Afterwards ra1=2, ra2=3 give rd1=2, rd2=3.
- Reg 7 holds 32'hAAAA_AAAA; in the same cycle reset=1, we=1, a3=7, wd=32'h5555_5555 -> next cycle reg 7 reads 0 and trace_valid=0.
- ra1=ra2=9 with commit to reg 9, wd=32'hCAFE_0009 -> rd1=rd2=32'hCAFE_0009 in that cycle. Then commit to reg 10 with ra1=9 -> rd1 reads 32'hCAFE_0009 from the array, with no false bypass.
